pc_sequencer: RTL and testbench

Program-counter sequencer for the MIPS fetch path. It owns the PC register and handshakes each fetch with instruction memory. It computes the next PC: sequential PC+4, a branch target (sign-extended 16-bit offset shifted left twice, added to PC+4), or a jump target (26-bit index shifted left twice, concatenated with the upper PC+4 bits). If a branch or jump arrives while a fetch cannot complete, the block holds it in a redirect register until the fetch handshake completes.

---
 rtl/pc_sequencer.sv | 104 ++++++++++
 tb/tb_pc_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// MIPS fetch-path program counter: owns the PC, handshakes fetches with
// instruction memory and holds a branch/jump target until the fetch can complete.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        imem_ready,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [15:0] branch_imm,
   input  logic        jump,
   input  logic [25:0] jump_index,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_valid,
   output logic        redirect_pending
);

   typedef enum logic {
      IDLE,
      RUN
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] redirect_q, redirect_d;
   logic        fetchValid_q, fetchValid_d;
   logic        redirectPending_q, redirectPending_d;

   logic [31:0] pcPlus4;
   logic [31:0] branchTarget;
   logic [31:0] jumpTarget;
   logic [31:0] requestTarget;
   logic        redirectRequest;
   logic        fetchDone;

   assign pcPlus4         = pc_q + 32'd4;
   assign branchTarget    = pcPlus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
   assign jumpTarget      = {pcPlus4[31:28], jump_index, 2'b00};
   assign requestTarget   = jump ? jumpTarget : branchTarget;
   assign redirectRequest = jump | branch_taken;
   assign fetchDone       = fetchValid_q & imem_ready & ~stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= IDLE;
         pc_q              <= RESET_PC;
         redirect_q        <= 32'h0000_0000;
         fetchValid_q      <= 1'b0;
         redirectPending_q <= 1'b0;
      end else begin
         state_q           <= state_d;
         pc_q              <= pc_d;
         redirect_q        <= redirect_d;
         fetchValid_q      <= fetchValid_d;
         redirectPending_q <= redirectPending_d;
      end
   end

   // A held redirect always beats same-cycle requests; the first captured target wins.
   always_comb begin
      state_d           = state_q;
      pc_d              = pc_q;
      redirect_d        = redirect_q;
      fetchValid_d      = fetchValid_q;
      redirectPending_d = redirectPending_q;
      unique case (state_q)
         IDLE: begin
            state_d      = RUN;
            fetchValid_d = 1'b1;
         end
         RUN: begin
            fetchValid_d = 1'b1;
            if (fetchDone) begin
               if (redirectPending_q) begin
                  pc_d              = redirect_q;
                  redirectPending_d = 1'b0;
               end else if (jump) begin
                  pc_d = jumpTarget;
               end else if (branch_taken) begin
                  pc_d = branchTarget;
               end else begin
                  pc_d = pcPlus4;
               end
            end else if (!redirectPending_q && redirectRequest) begin
               redirect_d        = requestTarget;
               redirectPending_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      pc               = pc_q;
      pc_plus4         = pcPlus4;
      fetch_valid      = fetchValid_q;
      redirect_pending = redirectPending_q;
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a directed vector table followed by
// randomized traffic compared against an arithmetic reference model.
module tb_pc_sequencer;

   logic        clk;
   logic        rst;
   logic        imem_ready;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_imm;
   logic        jump;
   logic [25:0] jump_index;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_valid;
   logic        redirect_pending;

   int checks = 0;
   int errors = 0;

   pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
      .clk              (clk),
      .rst              (rst),
      .imem_ready       (imem_ready),
      .stall            (stall),
      .branch_taken     (branch_taken),
      .branch_imm       (branch_imm),
      .jump             (jump),
      .jump_index       (jump_index),
      .pc               (pc),
      .pc_plus4         (pc_plus4),
      .fetch_valid      (fetch_valid),
      .redirect_pending (redirect_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        stl;
      logic        br;
      logic [15:0] imm;
      logic        jmp;
      logic [25:0] idx;
      logic [31:0] expPc;
      logic        expFv;
      logic        expRp;
   } vec_t;

   vec_t vecs[$];

   // Reference model state: whether fetching has started, the PC and any held target.
   bit          mRunning;
   logic [31:0] mPc;
   bit          mPending;
   logic [31:0] mTarget;

   task automatic modelStep();
      logic [31:0]        next4;
      logic signed [31:0] offset;
      logic [31:0]        bTarget;
      logic [31:0]        jTarget;
      next4   = mPc + 32'd4;
      offset  = $signed(branch_imm);
      bTarget = next4 + 32'(offset * 4);
      jTarget = (next4 & 32'hF000_0000) | (32'(jump_index) << 2);
      if (rst) begin
         mRunning = 0;
         mPc      = 32'h0000_0000;
         mPending = 0;
         mTarget  = 32'h0000_0000;
      end else if (!mRunning) begin
         mRunning = 1;
      end else if (imem_ready && !stall) begin
         if (mPending) begin
            mPc      = mTarget;
            mPending = 0;
         end else if (jump) mPc = jTarget;
         else if (branch_taken) mPc = bTarget;
         else mPc = next4;
      end else if (!mPending && (jump || branch_taken)) begin
         mTarget  = jump ? jTarget : bTarget;
         mPending = 1;
      end
   endtask

   task automatic applyStimulus(input logic r, input logic rdy, input logic stl,
                                input logic br, input logic [15:0] imm,
                                input logic jmp, input logic [25:0] idx);
      rst          = r;
      imem_ready   = rdy;
      stall        = stl;
      branch_taken = br;
      branch_imm   = imm;
      jump         = jmp;
      jump_index   = idx;
      modelStep();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] expPc,
                              input logic expFv, input logic expRp);
      logic [31:0] expP4;
      expP4 = expPc + 32'd4;
      checks++;
      if (pc !== expPc) begin
         errors++;
         $display("[TB] FAIL %s pc got %h expected %h", name, pc, expPc);
      end
      checks++;
      if (pc_plus4 !== expP4) begin
         errors++;
         $display("[TB] FAIL %s pc_plus4 got %h expected %h", name, pc_plus4, expP4);
      end
      checks++;
      if (fetch_valid !== expFv) begin
         errors++;
         $display("[TB] FAIL %s fetch_valid got %b expected %b", name, fetch_valid, expFv);
      end
      checks++;
      if (redirect_pending !== expRp) begin
         errors++;
         $display("[TB] FAIL %s redirect_pending got %b expected %b", name, redirect_pending, expRp);
      end
   endtask

   initial begin
      // rst rdy stl br imm jmp idx | pc fv rp
      vecs.push_back('{1, 0, 0, 0, 16'h0000, 0, 26'h0, 32'h0000_0000, 0, 0});
      vecs.push_back('{1, 0, 0, 0, 16'h0000, 0, 26'h0, 32'h0000_0000, 0, 0});
      vecs.push_back('{0, 1, 0, 1, 16'h0005, 1, 26'h7, 32'h0000_0000, 1, 0});
      vecs.push_back('{0, 1, 0, 0, 16'h0000, 0, 26'h0, 32'h0000_0004, 1, 0});
      vecs.push_back('{0, 1, 0, 0, 16'h0000, 0, 26'h0, 32'h0000_0008, 1, 0});
      vecs.push_back('{0, 1, 0, 0, 16'h0000, 0, 26'h0, 32'h0000_000C, 1, 0});
      vecs.push_back('{0, 1, 0, 0, 16'h0000, 1, 26'h40, 32'h0000_0100, 1, 0});
      vecs.push_back('{0, 1, 0, 1, 16'h0003, 0, 26'h0, 32'h0000_0110, 1, 0});
      vecs.push_back('{0, 1, 0, 1, 16'hFFFF, 0, 26'h0, 32'h0000_0110, 1, 0});
      vecs.push_back('{0, 1, 0, 1, 16'h0001, 1, 26'h10, 32'h0000_0040, 1, 0});
      vecs.push_back('{0, 1, 0, 0, 16'h0000, 1, 26'h80, 32'h0000_0200, 1, 0});
      vecs.push_back('{0, 1, 1, 1, 16'h0004, 0, 26'h0, 32'h0000_0200, 1, 1});
      vecs.push_back('{0, 1, 1, 0, 16'h0000, 1, 26'h999, 32'h0000_0200, 1, 1});
      vecs.push_back('{0, 1, 0, 0, 16'h0000, 1, 26'h999, 32'h0000_0214, 1, 0});
      vecs.push_back('{0, 0, 0, 1, 16'h0007, 0, 26'h0, 32'h0000_0214, 1, 1});
      vecs.push_back('{0, 0, 0, 0, 16'h0000, 0, 26'h0, 32'h0000_0214, 1, 1});
      vecs.push_back('{0, 1, 0, 0, 16'h0000, 0, 26'h0, 32'h0000_0234, 1, 0});
      vecs.push_back('{0, 1, 0, 1, 16'hFF71, 0, 26'h0, 32'hFFFF_FFFC, 1, 0});
      vecs.push_back('{0, 0, 0, 0, 16'h0000, 0, 26'h0, 32'hFFFF_FFFC, 1, 0});
      vecs.push_back('{0, 0, 0, 0, 16'h0000, 0, 26'h0, 32'hFFFF_FFFC, 1, 0});
      vecs.push_back('{0, 0, 0, 0, 16'h0000, 0, 26'h0, 32'hFFFF_FFFC, 1, 0});
      vecs.push_back('{0, 1, 0, 0, 16'h0000, 0, 26'h0, 32'h0000_0000, 1, 0});
      vecs.push_back('{0, 1, 0, 1, 16'hFFFD, 0, 26'h0, 32'hFFFF_FFF8, 1, 0});
      vecs.push_back('{0, 1, 0, 0, 16'h0000, 1, 26'h10, 32'hF000_0040, 1, 0});
      vecs.push_back('{0, 1, 1, 1, 16'h0002, 0, 26'h0, 32'hF000_0040, 1, 1});
      vecs.push_back('{1, 1, 0, 0, 16'h0000, 0, 26'h0, 32'h0000_0000, 0, 0});
      vecs.push_back('{0, 1, 0, 0, 16'h0000, 0, 26'h0, 32'h0000_0000, 1, 0});
      vecs.push_back('{0, 1, 0, 0, 16'h0000, 0, 26'h0, 32'h0000_0004, 1, 0});

      rst = 1'b1; imem_ready = 1'b0; stall = 1'b0; branch_taken = 1'b0;
      branch_imm = 16'h0; jump = 1'b0; jump_index = 26'h0;
      mRunning = 0; mPc = 32'h0; mPending = 0; mTarget = 32'h0;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].rdy, vecs[i].stl, vecs[i].br,
                       vecs[i].imm, vecs[i].jmp, vecs[i].idx);
         checkOutput($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expFv, vecs[i].expRp);
      end

      // Random traffic: stalls, not-ready cycles and occasional resets mid-redirect.
      for (int n = 0; n < 2000; n++) begin
         applyStimulus(($urandom_range(63) == 0),
                       ($urandom_range(3) != 0),
                       ($urandom_range(3) == 0),
                       ($urandom_range(3) == 0),
                       16'($urandom),
                       ($urandom_range(5) == 0),
                       26'($urandom));
         checkOutput($sformatf("rand%0d", n), mPc, mRunning, mPending);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
